timer_cmd_tx: RTL and testbench

- Initiator side of the serial delay-timer command link.
- Serialises a start pattern (1101) followed by a 4-bit delay value, MSB first, onto a single data line.
- Waits for the timer's done, returns a one-cycle ack, and reports completion or timeout to the local host.
- Sits between host control logic and the timer block that searches for the pattern, shifts in the delay, counts down and raises done.

---
 rtl/timer_link_pkg.sv | 8 +
 rtl/piso_shift8.sv | 16 +
 rtl/timer_cmd_tx.sv | 83 ++++++++
 tb/tb_timer_cmd_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_link_pkg.sv
// timer_link_pkg: shared constants and state encoding for the serial delay-timer command link.
package timer_link_pkg;
    localparam int         DELAY_W        = 4;
    localparam logic [3:0] PATTERN        = 4'b1101;
    localparam int         TICKS_PER_UNIT = 1000;
    localparam int         FRAME_W        = 4 + DELAY_W;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} state_t;
endpackage

// File: rtl/piso_shift8.sv
// piso_shift8: parallel-load, MSB-first serialiser; zeros shift in behind the frame.
module piso_shift8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_shift,
    input  logic [7:0] i_din,
    output logic       o_dout
);
    logic [7:0] r_sh;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_sh <= '0;
        else if (i_load) r_sh <= i_din;
        else if (i_shift) r_sh <= {r_sh[6:0], 1'b0};
    assign o_dout = r_sh[7];
endmodule

// File: rtl/timer_cmd_tx.sv
// timer_cmd_tx: sends {PATTERN, delay} MSB-first to the delay timer, then waits for done,
// acks it and reports completion or timeout to the host.
module timer_cmd_tx
    import timer_link_pkg::*;
#(
    parameter int WAIT_MAX = 20000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay,
    output logic               data,
    input  logic               done,
    output logic               ack,
    output logic               busy,
    output logic               complete,
    output logic               timeout
);
    localparam int WCNT_W = $clog2(WAIT_MAX);

    state_t            r_state, w_next;
    logic [2:0]        r_bit_cnt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_ack, r_busy, r_timeout;
    logic              w_load, w_shift, w_timeout;

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_next = SEND;
                w_load = 1'b1;
            end
            SEND: begin
                w_shift = 1'b1;
                w_next  = (r_bit_cnt == 3'd7) ? WAIT : SEND;
            end
            WAIT: if (done) w_next = ACK;
            else if (r_wait_cnt == WCNT_W'(WAIT_MAX - 1)) begin
                w_next    = IDLE;
                w_timeout = 1'b1;
            end
            ACK: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_bit_cnt  <= w_load ? 3'd0 : w_shift ? r_bit_cnt + 3'd1 : r_bit_cnt;
            r_wait_cnt <= (r_state == SEND) ? '0 :
                          (r_state == WAIT && !done && r_wait_cnt != '1) ? r_wait_cnt + 1'b1 : r_wait_cnt;
            r_ack      <= (w_next == ACK);
            r_busy     <= (w_next != IDLE);
            r_timeout  <= w_timeout;
        end

    // The 8th shift empties the register, so data returns to 0 on the same edge WAIT is entered.
    piso_shift8 u_piso (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_shift(w_shift),
        .i_din  ({PATTERN, delay}),
        .o_dout (data)
    );

    assign ack      = r_ack;
    assign complete = r_ack;
    assign busy     = r_busy;
    assign timeout  = r_timeout;
endmodule

// File: tb/tb_timer_cmd_tx.sv
// tb_timer_cmd_tx: drives timer_cmd_tx against a behavioural delay-timer and a serial-bit scoreboard.
module tb_timer_cmd_tx;
    import timer_link_pkg::*;
    localparam int WAIT_MAX = 20000;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [DELAY_W-1:0] delay = '0;
    logic data, done, ack, busy, complete, timeout;
    logic d_force = 1'b0, t_never = 1'b0, t_done;
    int n_chk = 0, n_fail = 0, n_acc = 0, tx_left = 0;
    bit exp_q[$];

    always #5 clk = ~clk;
    assign done = t_done | d_force;

    timer_cmd_tx #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(rst), .start(start), .delay(delay), .data(data), .done(done),
        .ack(ack), .busy(busy), .complete(complete), .timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Behavioural timer: search pattern, shift delay, count, hold done until ack.
    logic [1:0] t_st, t_n;
    logic [2:0] t_hist;
    logic [3:0] t_dly;
    int t_cnt;
    always @(posedge clk or posedge rst)
        if (rst) begin
            t_st <= 0; t_n <= 0; t_hist <= 0; t_dly <= 0; t_cnt <= 0; t_done <= 0;
        end else case (t_st)
            2'd0: begin
                t_hist <= {t_hist[1:0], data};
                if ({t_hist, data} == PATTERN) begin t_st <= 2'd1; t_n <= 0; end
            end
            2'd1: begin
                t_dly <= {t_dly[2:0], data};
                t_n <= t_n + 2'd1;
                if (t_n == 2'd3) begin
                    t_st  <= 2'd2;
                    t_cnt <= (int'({t_dly[2:0], data}) + 1) * TICKS_PER_UNIT - 1;
                end
            end
            2'd2: if (t_cnt == 0) begin
                t_st <= t_never ? 2'd0 : 2'd3;
                t_done <= !t_never;
                t_hist <= 0;
            end else t_cnt <= t_cnt - 1;
            default: if (ack) begin t_done <= 0; t_st <= 2'd0; t_hist <= 0; end
        endcase

    // Scoreboard: push the expected frame when a start is taken, pop one bit per cycle.
    always @(posedge clk or posedge rst)
        if (rst) begin
            exp_q.delete();
            tx_left <= 0;
        end else if (start && !busy) begin
            logic [7:0] f;
            f = {PATTERN, delay};
            for (int i = 7; i >= 0; i--) exp_q.push_back(f[i]);
            tx_left <= 8;
            n_acc++;
        end else if (tx_left > 0) tx_left <= tx_left - 1;

    always @(negedge clk)
        if (!rst) begin
            if (tx_left > 0) begin
                bit b;
                b = exp_q.pop_front();
                check("data_bit", data, b);
            end else check("data_idle", data, 0);
        end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [3:0] d);
        start = 1; delay = d;
        @(negedge clk);
        start = 0;
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_ack(input string tag, input int min_cyc, input int budget);
        int k;
        k = 0;
        while (!ack && !timeout && k < budget) begin @(negedge clk); k++; end
        check({tag, "_ack"}, ack, 1);
        check({tag, "_complete"}, complete, 1);
        check({tag, "_min_latency"}, k >= min_cyc, 1);
        @(negedge clk);
        check({tag, "_ack_pulse"}, ack, 0);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_done_fall"}, done, 0);
    endtask

    initial begin
        int k;
        bit saw_ack;
        tick(3);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_complete", complete, 0);
        check("rst_timeout", timeout, 0);
        rst = 0;
        tick(1);
        check("idle_busy", busy, 0);

        send(4'b0101);
        tick(7);
        check("last_bit", data, 1);
        tick(1);
        check("wait_data", data, 0);
        check("wait_busy", busy, 1);
        wait_ack("d5", 5900, 8000);

        send(4'h0);
        wait_ack("d0", 900, 2000);

        t_never = 1;
        send(4'hF);
        tick(8);
        k = 0; saw_ack = 0;
        while (!timeout && k < WAIT_MAX + 10) begin @(negedge clk); k++; saw_ack |= ack; end
        check("to_latency", k, WAIT_MAX);
        check("to_no_ack", saw_ack, 0);
        tick(1);
        check("to_pulse", timeout, 0);
        check("to_busy_fall", busy, 0);
        t_never = 0;

        start = 1; delay = 4'h3;
        tick(1);
        check("t4_busy", busy, 1);
        delay = 4'h9; d_force = 1;
        tick(2);
        d_force = 0;
        tick(2);
        start = 0;
        check("t4_no_early_ack", ack, 0);
        tick(5);
        start = 1;
        tick(1);
        start = 0;
        check("t4_wait_busy", busy, 1);
        check("t4_wait_no_ack", ack, 0);
        wait_ack("d3_ign", 3900, 6000);
        check("accept_count_a", n_acc, 4);

        send(4'h6);
        tick(3);
        check("pre_rst_bit", data, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_complete", complete, 0);
        check("mid_rst_timeout", timeout, 0);
        tick(1);
        rst = 0;
        tick(1);
        send(4'h6);
        wait_ack("after_rst", 5900, 9000);

        start = 1; delay = 4'h2;
        tick(1);
        check("b2b_busy", busy, 1);
        wait_ack("b2b1", 2900, 5000);
        check("b2b_gap_data", data, 0);
        tick(1);
        check("b2b_restart_busy", busy, 1);
        check("b2b_restart_data", data, 1);
        start = 0;
        wait_ack("b2b2", 2900, 5000);
        check("accept_count_b", n_acc, 8);
        check("queue_empty", exp_q.size(), 0);
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
